isp_vid_tpg: RTL and testbench

- Bayer raw video source that drives the ISP input stream (href/vsync/raw): the transmitter end of the pixel interface the ISP pipeline consumes.
- Generates complete frames with programmable blanking and selectable test patterns.
- Used to exercise the ISP without a sensor, and as a bring-up source on the board.
- Output timing matches sensor DVP convention: vsync high during the sync lines, href high for exactly WIDTH pixels per active line.

---
 rtl/isp_vid_tpg.sv | 183 ++++++++++++++++++
 tb/tb_isp_vid_tpg.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/isp_vid_tpg.sv
// isp_vid_tpg: Bayer raw test-pattern source with sensor-DVP timing (vsync / href / raw).
// Latency: all outputs registered; the first vsync cycle follows the enable-sampling edge.
// Backpressure: none (free-running source); enable and pattern are only sampled at frame boundaries.
// Ports: pclk/rst clock and async active-high reset; enable, pattern and solid_val are run controls;
//        out_href/out_vsync/out_raw form the pixel stream; frame_done and frame_cnt report completed frames.
module isp_vid_tpg #(
  parameter int BITS        = 8,
  parameter int WIDTH       = 1280,
  parameter int HEIGHT      = 960,
  parameter int HBLANK      = 160,
  parameter int VSYNC_LINES = 2,
  parameter int VBP_LINES   = 8,
  parameter int VFP_LINES   = 8,
  parameter int BAYER       = 0
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            enable,
  input  logic [1:0]      pattern,
  input  logic [BITS-1:0] solid_val,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_raw,
  output logic            frame_done,
  output logic [15:0]     frame_cnt
);

  localparam int LINE_LEN  = WIDTH + HBLANK;
  localparam int MAX_A     = (HEIGHT > VSYNC_LINES) ? HEIGHT : VSYNC_LINES;
  localparam int MAX_B     = (VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES;
  localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  // Counters are at least 5 bits wide so bit 4 (checkerboard square select) always exists.
  localparam int XW        = ($clog2(LINE_LEN) > 5) ? $clog2(LINE_LEN) : 5;
  localparam int YW        = ($clog2(MAX_LINES) > 5) ? $clog2(MAX_LINES) : 5;
  localparam int BAR_W     = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;
  localparam int BCW       = ($clog2(BAR_W) > 0) ? $clog2(BAR_W) : 1;

  localparam logic [XW-1:0]   X_LAST   = XW'(LINE_LEN - 1);
  localparam logic [XW-1:0]   X_ACT    = XW'(WIDTH);
  localparam logic [YW-1:0]   VS_LAST  = YW'(VSYNC_LINES - 1);
  localparam logic [YW-1:0]   VBP_LAST = YW'(VBP_LINES - 1);
  localparam logic [YW-1:0]   ACT_LAST = YW'(HEIGHT - 1);
  localparam logic [YW-1:0]   VFP_LAST = YW'(VFP_LINES - 1);
  localparam logic [BCW-1:0]  BAR_LAST = BCW'(BAR_W - 1);
  localparam logic [1:0]      BAYER_V  = 2'(BAYER);
  localparam logic [BITS-1:0] MAXV     = '1;

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

  // Registers describe the position currently shown on the outputs.
  state_t          st;
  logic [XW-1:0]   x;
  logic [YW-1:0]   ln;
  logic [2:0]      bar;
  logic [BCW-1:0]  bcnt;
  logic [1:0]      pat_l;
  logic [BITS-1:0] solid_l;

  state_t          nst;
  logic [XW-1:0]   nx;
  logic [YW-1:0]   nln;
  logic [2:0]      nbar;
  logic [BCW-1:0]  nbcnt;
  logic            start;
  logic            nlast;
  logic            nhref;
  logic            px, py, flag;
  logic [BITS-1:0] npix;

  always_comb begin
    nst   = st;
    nx    = x;
    nln   = ln;
    start = 1'b0;
    if (st == IDLE) begin
      if (enable) begin
        nst   = VSYNC;
        nx    = '0;
        nln   = '0;
        start = 1'b1;
      end
    end else if (frame_done) begin
      // frame_done marks the final cycle of the frame, so it doubles as the frame-end condition.
      nx  = '0;
      nln = '0;
      if (enable) begin
        nst   = VSYNC;
        start = 1'b1;
      end else begin
        nst = IDLE;
      end
    end else if (x == X_LAST) begin
      nx  = '0;
      nln = ln + YW'(1);
      case (st)
        VSYNC:   if (ln == VS_LAST) begin
                   nln = '0;
                   nst = (VBP_LINES == 0) ? ACTIVE : VBP;
                 end
        VBP:     if (ln == VBP_LAST) begin
                   nln = '0;
                   nst = ACTIVE;
                 end
        ACTIVE:  if (ln == ACT_LAST) begin
                   nln = '0;
                   nst = VFP;
                 end
        default: ;
      endcase
    end else begin
      nx = x + XW'(1);
    end

    // Bar index tracks nx with a boundary counter instead of dividing by the bar width.
    nbar  = bar;
    nbcnt = bcnt;
    if (nx == '0) begin
      nbar  = '0;
      nbcnt = '0;
    end else if (bcnt == BAR_LAST) begin
      nbcnt = '0;
      if (bar != 3'd7) nbar = bar + 3'd1;
    end else begin
      nbcnt = bcnt + BCW'(1);
    end

    if (VFP_LINES > 0)
      nlast = (nst == VFP) && (nln == VFP_LAST) && (nx == X_LAST);
    else
      nlast = (nst == ACTIVE) && (nln == ACT_LAST) && (nx == X_LAST);

    nhref = (nst == ACTIVE) && (nx < X_ACT);

    // Bar colour flags: R set on bars 0,1,4,5; G on bars 0-3; B on even bars.
    px = nx[0] ^ BAYER_V[0];
    py = nln[0] ^ BAYER_V[1];
    case ({py, px})
      2'b00:   flag = ~nbar[1];
      2'b11:   flag = ~nbar[0];
      default: flag = ~nbar[2];
    endcase

    case (pat_l)
      2'd0:    npix = solid_l;
      2'd1:    npix = BITS'(nx);
      2'd2:    npix = flag ? MAXV : '0;
      default: npix = (nx[4] ^ nln[4]) ? MAXV : '0;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      x          <= '0;
      ln         <= '0;
      bar        <= '0;
      bcnt       <= '0;
      pat_l      <= '0;
      solid_l    <= '0;
      out_href   <= 1'b0;
      out_vsync  <= 1'b0;
      out_raw    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      st   <= nst;
      x    <= nx;
      ln   <= nln;
      bar  <= nbar;
      bcnt <= nbcnt;
      if (start) begin
        pat_l   <= pattern;
        solid_l <= solid_val;
      end
      out_href   <= nhref;
      out_vsync  <= (nst == VSYNC);
      out_raw    <= nhref ? npix : '0;
      frame_done <= nlast;
      if (nlast) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_isp_vid_tpg.sv
// tb_isp_vid_tpg: directed + randomized frame sequences on three generator instances
// (BAYER=0, BAYER=3, and BAYER=0 with no front porch), every output compared per cycle
// against a frame-position model computed from line/pixel arithmetic.
module tb_isp_vid_tpg;

  localparam int W   = 16;
  localparam int H   = 4;
  localparam int HB  = 4;
  localparam int VS  = 1;
  localparam int VBP = 1;
  localparam int LL  = W + HB;
  localparam int RF[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
  localparam int GF[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  localparam int BF[8] = '{1, 0, 1, 0, 1, 0, 1, 0};

  typedef struct packed {
    logic       href;
    logic       vsync;
    logic       done;
    logic [7:0] raw;
  } exp_t;

  logic       pclk = 1'b0;
  logic       rst;
  logic       en0;
  logic       enz;
  logic [1:0] pattern;
  logic [7:0] solid_val;

  logic [2:0]  href_o, vsync_o, done_o;
  logic [7:0]  raw_o [3];
  logic [15:0] cnt_o [3];
  logic [15:0] cnt   [3];

  int checks = 0;
  int errors = 0;
  int curp, curs, np, ns, ct;

  always #5 pclk = ~pclk;

  isp_vid_tpg #(.BITS(8), .WIDTH(W), .HEIGHT(H), .HBLANK(HB), .VSYNC_LINES(VS),
                .VBP_LINES(VBP), .VFP_LINES(1), .BAYER(0)) dut0 (
    .pclk(pclk), .rst(rst), .enable(en0), .pattern(pattern), .solid_val(solid_val),
    .out_href(href_o[0]), .out_vsync(vsync_o[0]), .out_raw(raw_o[0]),
    .frame_done(done_o[0]), .frame_cnt(cnt_o[0]));

  isp_vid_tpg #(.BITS(8), .WIDTH(W), .HEIGHT(H), .HBLANK(HB), .VSYNC_LINES(VS),
                .VBP_LINES(VBP), .VFP_LINES(1), .BAYER(3)) dut3 (
    .pclk(pclk), .rst(rst), .enable(en0), .pattern(pattern), .solid_val(solid_val),
    .out_href(href_o[1]), .out_vsync(vsync_o[1]), .out_raw(raw_o[1]),
    .frame_done(done_o[1]), .frame_cnt(cnt_o[1]));

  isp_vid_tpg #(.BITS(8), .WIDTH(W), .HEIGHT(H), .HBLANK(HB), .VSYNC_LINES(VS),
                .VBP_LINES(VBP), .VFP_LINES(0), .BAYER(0)) dutz (
    .pclk(pclk), .rst(rst), .enable(enz), .pattern(pattern), .solid_val(solid_val),
    .out_href(href_o[2]), .out_vsync(vsync_o[2]), .out_raw(raw_o[2]),
    .frame_done(done_o[2]), .frame_cnt(cnt_o[2]));

  // Expected outputs at cycle t of a frame (t=0 is the first vsync cycle).
  function automatic exp_t model(input int t, input int pat, input int solid,
                                 input int bayer, input int vfp);
    exp_t e;
    int line, xx, y, b, px, py, f;
    e    = '0;
    line = t / LL;
    xx   = t % LL;
    if (line < VS) begin
      e.vsync = 1'b1;
    end else if (line >= VS + VBP && line < VS + VBP + H && xx < W) begin
      y      = line - VS - VBP;
      e.href = 1'b1;
      case (pat)
        0: e.raw = 8'(solid);
        1: e.raw = 8'(xx);
        2: begin
          b  = xx / (W / 8);
          if (b > 7) b = 7;
          px = (xx % 2) ^ (bayer % 2);
          py = (y % 2) ^ (bayer / 2);
          if (px == 0 && py == 0)      f = RF[b];
          else if (px == 1 && py == 1) f = BF[b];
          else                         f = GF[b];
          e.raw = (f != 0) ? 8'hFF : 8'h00;
        end
        default: e.raw = ((((xx / 16) % 2) ^ ((y / 16) % 2)) != 0) ? 8'hFF : 8'h00;
      endcase
    end
    e.done = (t == (VS + VBP + H + vfp) * LL - 1);
    return e;
  endfunction

  task automatic chk(input int i, input string tag, input int t,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL dut%0d %s t=%0d observed=%0h expected=%0h", i, tag, t, obs, exp);
    end
  endtask

  task automatic check_dut(input int i, input int t, input int pat, input int solid,
                           input int bayer, input int vfp);
    exp_t e;
    logic [15:0] ec;
    e  = model(t, pat, solid, bayer, vfp);
    ec = e.done ? cnt[i] + 16'd1 : cnt[i];
    chk(i, "href", t, href_o[i], e.href);
    chk(i, "vsync", t, vsync_o[i], e.vsync);
    chk(i, "raw", t, raw_o[i], e.raw);
    chk(i, "frame_done", t, done_o[i], e.done);
    chk(i, "frame_cnt", t, cnt_o[i], ec);
    cnt[i] = ec;
  endtask

  task automatic check_idle(input int i, input int t);
    chk(i, "idle_href", t, href_o[i], 1'b0);
    chk(i, "idle_vsync", t, vsync_o[i], 1'b0);
    chk(i, "idle_raw", t, raw_o[i], 8'h00);
    chk(i, "idle_done", t, done_o[i], 1'b0);
    chk(i, "idle_cnt", t, cnt_o[i], cnt[i]);
  endtask

  // Runs one frame (or its first len cycles) from t=0, at t==chg_t applies new inputs.
  task automatic run_frame(input bit z, input int len, input int pat, input int solid,
                           input int chg_t, input int npat, input int nsolid, input bit nen);
    int p;
    p = z ? (VS + VBP + H) * LL : (VS + VBP + H + 1) * LL;
    if (len > 0) p = len;
    for (int t = 0; t < p; t++) begin
      if (z) begin
        check_dut(2, t, pat, solid, 0, 0);
      end else begin
        check_dut(0, t, pat, solid, 0, 1);
        check_dut(1, t, pat, solid, 3, 1);
      end
      if (t == chg_t) begin
        pattern   = 2'(npat);
        solid_val = 8'(nsolid);
        if (z) enz = nen;
        else   en0 = nen;
      end
      @(negedge pclk);
    end
  endtask

  initial begin
    rst       = 1'b1;
    en0       = 1'b0;
    enz       = 1'b0;
    pattern   = 2'd1;
    solid_val = 8'h00;
    for (int i = 0; i < 3; i++) cnt[i] = 16'h0000;

    repeat (3) @(negedge pclk);
    for (int i = 0; i < 3; i++) check_idle(i, 0);
    rst = 1'b0;
    @(negedge pclk);

    // Ramp frames; a mid-frame pattern change in frame 3 must not take effect until frame 4.
    en0 = 1'b1;
    @(negedge pclk);
    run_frame(0, 0, 1, 0, -1, 0, 0, 1);
    run_frame(0, 0, 1, 0, -1, 0, 0, 1);
    run_frame(0, 0, 1, 0, 60, 0, 8'h5A, 1);
    // Solid 0x5A, changed to 0x11 mid-frame.
    run_frame(0, 0, 0, 8'h5A, 70, 0, 8'h11, 1);
    run_frame(0, 0, 0, 8'h11, 10, 2, 8'h11, 1);
    // Colour bars on both Bayer phases, then checkerboard with enable dropped mid-ACTIVE.
    run_frame(0, 0, 2, 8'h11, 30, 3, 8'h11, 1);
    run_frame(0, 0, 3, 8'h11, 90, 1, 8'h11, 0);
    for (int t = 0; t < 100; t++) begin
      check_idle(0, t);
      check_idle(1, t);
      @(negedge pclk);
    end

    // Randomized back-to-back frames with random mid-frame input changes.
    curp      = $urandom_range(0, 3);
    curs      = $urandom_range(0, 255);
    pattern   = 2'(curp);
    solid_val = 8'(curs);
    en0       = 1'b1;
    @(negedge pclk);
    for (int k = 0; k < 4; k++) begin
      np = $urandom_range(0, 3);
      ns = $urandom_range(0, 255);
      ct = $urandom_range(0, 138);
      run_frame(0, 0, curp, curs, ct, np, ns, 1);
      curp = np;
      curs = ns;
    end

    // Reset pulse while href is high (line 0, x=5).
    run_frame(0, 45, curp, curs, -1, 0, 0, 1);
    chk(0, "href_before_rst", 45, href_o[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 16'h0000;
      check_idle(i, 45);
    end
    @(negedge pclk);
    rst = 1'b0;
    @(negedge pclk);
    run_frame(0, 0, curp, curs, 50, curp, curs, 0);
    for (int t = 0; t < 20; t++) begin
      check_idle(0, t);
      @(negedge pclk);
    end

    // No front porch: frame_done on the final HBLANK cycle and frame_cnt wrapping.
    force dutz.frame_cnt = 16'hFFFE;
    #1;
    release dutz.frame_cnt;
    cnt[2] = 16'hFFFE;
    @(negedge pclk);
    check_idle(2, 0);
    pattern   = 2'd1;
    solid_val = 8'h00;
    enz       = 1'b1;
    @(negedge pclk);
    run_frame(1, 0, 1, 0, -1, 1, 0, 1);
    run_frame(1, 0, 1, 0, 50, 1, 0, 0);
    for (int t = 0; t < 10; t++) begin
      check_idle(2, t);
      @(negedge pclk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
